// File: rtl/sdram_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single SDRAM controller port.
// Optional DMA anti-starvation counter: define SDRAM_ARB_STARVE_GUARD_EN.
module sdram_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              gnt_dma_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              mem_req_q, cpu_ack_q, dma_ack_q, busy_q;
    logic              pick_dma;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    // Counts CPU grants made while DMA was waiting; at the limit DMA wins a tie.
    always_comb begin
        pick_dma = dma_req && (!cpu_req || starve_q == CNT_W'(STARVE_LIMIT));
        starve_d = starve_q;
        if (state_q == IDLE && (cpu_req || dma_req)) begin
            if (pick_dma || !dma_req) starve_d = '0;
            else                      starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    always_comb pick_dma = dma_req && !cpu_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_dma_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    if (cpu_req || dma_req) begin
                        gnt_dma_q <= pick_dma;
                        addr_q    <= pick_dma ? dma_addr  : cpu_addr;
                        we_q      <= pick_dma ? dma_we    : cpu_we;
                        wdata_q   <= pick_dma ? dma_wdata : cpu_wdata;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (gnt_dma_q) begin
                            dma_rdata_q <= mem_rdata;
                            dma_ack_q   <= 1'b1;
                        end else begin
                            cpu_rdata_q <= mem_rdata;
                            cpu_ack_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; expectations follow the starvation macro if defined.
module tb_sdram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
    logic [24:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata, mem_rdata;
    logic        cpu_ack, dma_ack, mem_req, mem_we, busy;
    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata;
    logic [24:0] mem_addr;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    sdram_arbiter #(.ADDR_W(25), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Waits (bounded) for mem_req, captures the request, returns ack one cycle later.
    task automatic do_mem(input logic [7:0] rd, output logic [1:0] acks, output int waits,
                          output logic [24:0] a, output logic w, output logic [7:0] wd);
        waits = 0;
        while (mem_req !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("mem_req_seen", 32'(mem_req), 32'd1);
        a  = mem_addr;
        w  = mem_we;
        wd = mem_wdata;
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        acks = {dma_ack, cpu_ack};
    endtask

    logic [1:0]  acks;
    int          waits;
    logic [24:0] a;
    logic        w;
    logic [7:0]  wd;

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        rst = 1'b0;

        // Single CPU read, address changed mid-access, ack two cycles after mem_req
        cpu_req = 1'b1; cpu_addr = 25'h0001234; cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_mem_req", 32'(mem_req), 32'd1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0001234);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        cpu_addr = 25'h0ABCDEF;
        @(negedge clk);
        chk("hold_mem_req", 32'(mem_req), 32'd1);
        chk("hold_mem_addr", 32'(mem_addr), 32'h0001234);
        @(negedge clk);
        chk("hold2_mem_addr", 32'(mem_addr), 32'h0001234);
        chk("hold_no_ack", 32'(cpu_ack), 32'd0);
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rd_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        chk("rd_dma_ack", 32'(dma_ack), 32'd0);
        chk("rd_mem_req_low", 32'(mem_req), 32'd0);
        chk("resp_mem_addr", 32'(mem_addr), 32'h0001234);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_ack_pulse", 32'(cpu_ack), 32'd0);
        chk("rd_idle_busy", 32'(busy), 32'd0);
        chk("rd_rdata_hold", 32'(cpu_rdata), 32'hA5);

        // Simultaneous request: CPU first, DMA right after
        cpu_req = 1'b1; cpu_addr = 25'h100; dma_req = 1'b1; dma_addr = 25'h200;
        do_mem(8'h11, acks, waits, a, w, wd);
        chk("sim_first_acks", 32'(acks), 32'b01);
        chk("sim_first_wait", 32'(waits), 32'd1);
        chk("sim_first_addr", 32'(a), 32'h100);
        chk("sim_first_rdata", 32'(cpu_rdata), 32'h11);
        cpu_req = 1'b0;
        do_mem(8'h22, acks, waits, a, w, wd);
        chk("sim_second_acks", 32'(acks), 32'b10);
        chk("sim_second_wait", 32'(waits), 32'd2);
        chk("sim_second_addr", 32'(a), 32'h200);
        chk("sim_dma_rdata", 32'(dma_rdata), 32'h22);
        chk("sim_cpu_rdata_hold", 32'(cpu_rdata), 32'h11);
        dma_req = 1'b0;
        @(negedge clk);

        // DMA write at top address
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h1FFFFFF; dma_wdata = 8'h3C;
        do_mem(8'h00, acks, waits, a, w, wd);
        chk("wr_acks", 32'(acks), 32'b10);
        chk("wr_addr", 32'(a), 32'h1FFFFFF);
        chk("wr_we", 32'(w), 32'd1);
        chk("wr_wdata", 32'(wd), 32'h3C);
        dma_req = 1'b0; dma_we = 1'b0;
        @(negedge clk);

        // Reset during ACCESS, late mem_ack in IDLE ignored
        cpu_req = 1'b1; cpu_addr = 25'h55;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        chk("abort_mem_req_low", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_acks", 32'({dma_ack, cpu_ack}), 32'd0);
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_mem_req", 32'(mem_req), 32'd0);
        cpu_req = 1'b1; cpu_addr = 25'h66;
        do_mem(8'h77, acks, waits, a, w, wd);
        chk("post_abort_acks", 32'(acks), 32'b01);
        chk("post_abort_addr", 32'(a), 32'h66);
        chk("post_abort_rdata", 32'(cpu_rdata), 32'h77);
        cpu_req = 1'b0;
        @(negedge clk);

        // Both requesters continuously requesting
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 25'h10; dma_req = 1'b1; dma_addr = 25'h20;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] exp_acks;
            exp_acks = (GUARD && (i % 5 == 4)) ? 2'b10 : 2'b01;
            do_mem(8'(i), acks, waits, a, w, wd);
            chk($sformatf("starve_acks_%0d", i), 32'(acks), 32'(exp_acks));
            chk($sformatf("starve_addr_%0d", i), 32'(a), exp_acks[1] ? 32'h20 : 32'h10);
            chk($sformatf("starve_wait_%0d", i), 32'(waits), (i == 0) ? 32'd1 : 32'd2);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25: width of all SDRAM byte addresses.
REQ-002 Parameter DATA_W, default 8: width of all data buses.
REQ-003 Parameter STARVE_LIMIT, default 4: number of consecutive CPU grants, while DMA waits, that forces a DMA grant.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-007 cpu_addr  input  ADDR_W  CPU SDRAM address, already mapped.
REQ-008 cpu_we  input  1  1=write, 0=read.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-011 cpu_rdata  output  DATA_W  CPU read data, valid while cpu_ack=1.
REQ-012 dma_req, dma_addr, dma_we, dma_wdata, dma_ack, dma_rdata  (same directions and widths as the cpu_* ports)  DMA requester port.
REQ-013 mem_req  output  1  request to SDRAM controller, held until mem_ack.
REQ-014 mem_addr  output  ADDR_W; mem_we  output  1; mem_wdata  output  DATA_W  latched access attributes.
REQ-015 mem_ack  input  1  one-cycle completion from SDRAM controller.
REQ-016 mem_rdata  input  DATA_W  read data, valid with mem_ack.
REQ-017 busy  output  1  high in every state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and RESP only.
REQ-019 IDLE: if any req=1, winner chosen, its addr/we/wdata latched, next state ACCESS; else stay IDLE.
REQ-020 Priority: CPU wins a simultaneous request unless the starvation rule (REQ-028) applies.
REQ-021 ACCESS: mem_req=1 with latched attributes, stable until mem_ack; on mem_ack, mem_rdata latched, next state RESP.
REQ-022 RESP: exactly the granted port's ack=1 for one cycle with latched rdata; next state IDLE.
REQ-023 Latency: req seen in IDLE at cycle N -> mem_req=1 at N+1; mem_ack at cycle M -> ack at M+1; IDLE at M+2; minimum 3 cycles per access.
REQ-024 Requests SHALL be sampled only in IDLE; req changes in ACCESS/RESP are ignored.
REQ-025 A requester SHALL drop req, or present a new access, in the cycle after its ack; the arbiter does not guard against a stale req.
REQ-026 mem_ack in IDLE or RESP SHALL be ignored.
REQ-027 cpu_rdata/dma_rdata SHALL hold their last value when not acked; write accesses also produce an ack; rdata is then undefined-but-stable.

Reset
REQ-028 (starvation counter, see Configuration) Counter increments on each CPU grant made while dma_req=1, clears on any DMA grant or CPU grant with dma_req=0; when count = STARVE_LIMIT, DMA wins the next simultaneous request.
REQ-029 On rst: state=IDLE, mem_req=0, cpu_ack=0, dma_ack=0, busy=0, starvation counter=0, latched addr/data/rdata=0.
REQ-030 rst in ACCESS or RESP SHALL abandon the access: no ack issued, mem_req=0 the following cycle.

Configuration
REQ-031 Macro SDRAM_ARB_STARVE_GUARD_EN: when defined, REQ-028 is compiled in; when undefined, the counter is absent and the CPU always wins, so DMA may starve indefinitely.

Verification
REQ-032 Single CPU read, cpu_addr=0x0001234, mem_ack 2 cycles after mem_req with mem_rdata=0xA5 -> mem_addr=0x0001234, cpu_ack pulse one cycle after mem_ack, cpu_rdata=0xA5, dma_ack stays 0.
REQ-033 cpu_req and dma_req asserted in the same cycle -> CPU served first; DMA served next with no intervening IDLE beyond one cycle.
REQ-034 With macro defined, STARVE_LIMIT=4, both requesters continuously requesting -> grant order C,C,C,C,D repeating; without macro -> only C granted.
REQ-035 DMA write dma_addr=0x1FFFFFF, dma_wdata=0x3C -> mem_we=1, mem_addr=0x1FFFFFF, mem_wdata=0x3C, dma_ack after mem_ack.
REQ-036 rst asserted during ACCESS, then mem_ack returned in IDLE -> no ack on either port, busy=0, next cpu_req served normally.
REQ-037 cpu_addr changed while in ACCESS -> mem_addr holds the value latched in IDLE until RESP.
